// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter between two requesters sharing one single-port command RAM.
// Each accepted transaction is expanded into a two-word command sequence and answered with one response pulse.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req0_valid,
    output logic                 o_req0_ready,
    input  logic                 i_req0_we,
    input  logic [ADDR_SIZE-1:0] i_req0_addr,
    input  logic [ADDR_SIZE-1:0] i_req0_wdata,
    input  logic                 i_req1_valid,
    output logic                 o_req1_ready,
    input  logic                 i_req1_we,
    input  logic [ADDR_SIZE-1:0] i_req1_addr,
    input  logic [ADDR_SIZE-1:0] i_req1_wdata,
    output logic                 o_rsp0_valid,
    output logic [ADDR_SIZE-1:0] o_rsp0_rdata,
    output logic                 o_rsp0_err,
    output logic                 o_rsp1_valid,
    output logic [ADDR_SIZE-1:0] o_rsp1_rdata,
    output logic                 o_rsp1_err,
    output logic [ADDR_SIZE+1:0] o_ram_din,
    output logic                 o_ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] i_ram_dout,
    input  logic                 i_ram_tx_valid
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_RESP} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_rr_last;
    logic                   r_owner;
    logic                   r_we;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [ADDR_SIZE-1:0]   r_wdata;
    logic [CW-1:0]          r_cnt;
    logic [ADDR_SIZE+1:0]   r_din_hold;
    logic [ADDR_SIZE-1:0]   r_rdata0;
    logic [ADDR_SIZE-1:0]   r_rdata1;
    logic                   r_err0;
    logic                   r_err1;

    logic                   w_grant;
    logic                   w_accept;
    logic                   w_timeout;
    logic                   w_rsp_load;
    logic [ADDR_SIZE-1:0]   w_rsp_rdata;
    logic                   w_rsp_err;

    // Round robin: a lone requester always wins; on contention the one not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (i_req0_valid && i_req1_valid) w_grant = ~r_rr_last;
        else if (i_req1_valid)            w_grant = 1'b1;
    end

    assign w_accept  = (r_state == S_IDLE) && (i_req0_valid || i_req1_valid);
    assign w_timeout = (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ADDR;
            S_ADDR:  w_next_state = S_DATA;
            S_DATA:  w_next_state = r_we ? S_RESP : S_WAIT;
            S_WAIT:  if (i_ram_tx_valid || w_timeout) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        o_req0_ready   = 1'b0;
        o_req1_ready   = 1'b0;
        o_ram_rx_valid = 1'b0;
        o_ram_din      = r_din_hold;
        o_rsp0_valid   = 1'b0;
        o_rsp1_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req0_ready = i_req0_valid && !w_grant;
                o_req1_ready = i_req1_valid &&  w_grant;
            end
            S_ADDR: begin
                o_ram_rx_valid = 1'b1;
                o_ram_din      = {(r_we ? 2'b00 : 2'b10), r_addr};
            end
            S_DATA: begin
                o_ram_rx_valid = 1'b1;
                o_ram_din      = r_we ? {2'b01, r_wdata} : {2'b11, {ADDR_SIZE{1'b0}}};
            end
            S_RESP: begin
                o_rsp0_valid = !r_owner;
                o_rsp1_valid =  r_owner;
            end
            default: ;
        endcase
    end

    // Result is captured on the cycle that enters RESP: writes carry no data, a timed-out read flags err.
    always_comb begin
        w_rsp_load  = (r_state == S_DATA && r_we) ||
                      (r_state == S_WAIT && (i_ram_tx_valid || w_timeout));
        w_rsp_rdata = (r_state == S_WAIT && i_ram_tx_valid) ? i_ram_dout : '0;
        w_rsp_err   = (r_state == S_WAIT) && !i_ram_tx_valid;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_last  <= 1'b1;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_din_hold <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            r_din_hold <= o_ram_din;
            r_cnt      <= (r_state == S_WAIT) ? r_cnt + CW'(1) : '0;
            if (w_accept) begin
                r_owner   <= w_grant;
                r_rr_last <= w_grant;
                r_we      <= w_grant ? i_req1_we    : i_req0_we;
                r_addr    <= w_grant ? i_req1_addr  : i_req0_addr;
                r_wdata   <= w_grant ? i_req1_wdata : i_req0_wdata;
            end
            if (w_rsp_load) begin
                if (r_owner) begin
                    r_rdata1 <= w_rsp_rdata;
                    r_err1   <= w_rsp_err;
                end else begin
                    r_rdata0 <= w_rsp_rdata;
                    r_err0   <= w_rsp_err;
                end
            end
        end
    end

    assign o_rsp0_rdata = r_rdata0;
    assign o_rsp0_err   = r_err0;
    assign o_rsp1_rdata = r_rdata1;
    assign o_rsp1_err   = r_err1;
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: a behavioural RAM, a transaction-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_ram_cmd_arbiter;
    localparam int AS = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, we0, v1, we1;
    logic [AS-1:0] addr0, wdata0, addr1, wdata1;
    logic          ready0, ready1;
    logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [AS-1:0] rsp0_rdata, rsp1_rdata;
    logic [AS+1:0] din;
    logic          rx;
    logic [AS-1:0] dout = '0;
    logic          tx   = 1'b0;
    logic          tx_en;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ram_cmd_arbiter #(.ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(ready0), .i_req0_we(we0),
        .i_req0_addr(addr0), .i_req0_wdata(wdata0),
        .i_req1_valid(v1), .o_req1_ready(ready1), .i_req1_we(we1),
        .i_req1_addr(addr1), .i_req1_wdata(wdata1),
        .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata), .o_rsp0_err(rsp0_err),
        .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata), .o_rsp1_err(rsp1_err),
        .o_ram_din(din), .o_ram_rx_valid(rx),
        .i_ram_dout(dout), .i_ram_tx_valid(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural command RAM: 00/10 latch address and clear tx_valid, 01 writes, 11 returns data.
    logic [AS-1:0] ram_mem [256];
    logic [AS-1:0] ram_ptr = '0;
    always @(posedge clk) begin
        if (rx) begin
            case (din[AS+1:AS])
                2'b00, 2'b10: begin ram_ptr <= din[AS-1:0]; tx <= 1'b0; end
                2'b01:        ram_mem[ram_ptr] <= din[AS-1:0];
                default:      if (tx_en) begin dout <= ram_mem[ram_ptr]; tx <= 1'b1; end
            endcase
        end
    end

    // Transaction-level reference: time since accept decides which command word or response is due.
    logic [AS-1:0] model_mem [256];
    bit            cmp_en = 0;
    bit            m_busy = 0;
    int            m_t, m_done_t;
    bit            m_owner, m_we, m_tx_en;
    logic [AS-1:0] m_addr, m_wdata;
    logic [AS+1:0] m_din_hold = '0;
    logic [AS-1:0] m_rdata [2];
    bit            m_err [2];
    bit            m_rr_last = 1;

    function automatic int grant_of(input logic a, input logic b, input bit last);
        if (a && b) return last ? 0 : 1;
        if (a)      return 0;
        if (b)      return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        int            g;
        logic          e_rdy0, e_rdy1, e_rx, e_rv0, e_rv1;
        logic [AS+1:0] e_din;
        g      = grant_of(v0, v1, m_rr_last);
        e_rdy0 = 0; e_rdy1 = 0; e_rx = 0; e_rv0 = 0; e_rv1 = 0;
        e_din  = m_din_hold;
        if (!m_busy) begin
            e_rdy0 = (g == 0);
            e_rdy1 = (g == 1);
        end else begin
            if (m_t == 1) begin
                e_rx = 1; e_din = {(m_we ? 2'b00 : 2'b10), m_addr};
            end else if (m_t == 2) begin
                e_rx = 1; e_din = m_we ? {2'b01, m_wdata} : {2'b11, {AS{1'b0}}};
            end
            if (m_t == m_done_t) begin
                m_rdata[m_owner] = (!m_we && m_tx_en) ? model_mem[m_addr] : '0;
                m_err[m_owner]   = !m_we && !m_tx_en;
                e_rv0 = !m_owner;
                e_rv1 =  m_owner;
            end
        end
        if (cmp_en) begin
            check("ready0", ready0, e_rdy0);
            check("ready1", ready1, e_rdy1);
            check("rx_valid", rx, e_rx);
            check("din", din, e_din);
            check("rsp0_valid", rsp0_valid, e_rv0);
            check("rsp1_valid", rsp1_valid, e_rv1);
            check("rsp0_rdata", rsp0_rdata, m_rdata[0]);
            check("rsp0_err", rsp0_err, m_err[0]);
            check("rsp1_rdata", rsp1_rdata, m_rdata[1]);
            check("rsp1_err", rsp1_err, m_err[1]);
        end
        // Advance to the state after the coming rising edge.
        if (m_busy && m_we && m_t == 2) model_mem[m_addr] = m_wdata;
        if (m_busy && (m_t == 1 || m_t == 2)) m_din_hold = e_din;
        if (rst) begin
            m_busy = 0; m_rr_last = 1; m_din_hold = '0;
            m_rdata[0] = '0; m_rdata[1] = '0; m_err[0] = 0; m_err[1] = 0;
            cmp_en = 1;
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy    = 1; m_t = 1; m_owner = (g == 1); m_rr_last = (g == 1);
                m_we      = (g == 1) ? we1 : we0;
                m_addr    = (g == 1) ? addr1 : addr0;
                m_wdata   = (g == 1) ? wdata1 : wdata0;
                m_tx_en   = tx_en;
                m_done_t  = m_we ? 3 : (tx_en ? 4 : TO + 4);
            end
        end else if (m_t == m_done_t) begin
            m_busy = 0;
        end else begin
            m_t++;
        end
    end

    task automatic drive(input int n, input logic v, input logic we, input logic [AS-1:0] a,
                         input logic [AS-1:0] d);
        if (n == 0) begin v0 = v; we0 = we; addr0 = a; wdata0 = d; end
        else        begin v1 = v; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    task automatic wait_accept(input int n, output int acc);
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            @(negedge clk);
            if (n == 0 ? ready0 : ready1) acc = cyc;
            @(posedge clk); #1;
        end
        check("accepted", 32'(acc >= 0), 32'd1);
    endtask

    // One transaction from requester n; returns response latency from accept plus the two command words.
    task automatic run_txn(input int n, input logic we, input logic [AS-1:0] a, input logic [AS-1:0] d,
                           output int lat, output logic [AS+1:0] d1, output logic [AS+1:0] d2,
                           output logic [AS-1:0] rd, output logic er, output logic other_v);
        int acc;
        bit got;
        lat = -1; d1 = 'x; d2 = 'x; rd = 'x; er = 'x; other_v = 0; got = 0;
        drive(n, 1, we, a, d);
        wait_accept(n, acc);
        drive(n, 0, ~we, 8'($urandom), 8'($urandom));
        if (acc < 0) return;
        @(negedge clk); d1 = din;
        @(negedge clk); d2 = din;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (n == 0 ? rsp1_valid : rsp0_valid) other_v = 1;
            if (n == 0 ? rsp0_valid : rsp1_valid) begin
                got = 1; lat = cyc - acc;
                rd  = (n == 0) ? rsp0_rdata : rsp1_rdata;
                er  = (n == 0) ? rsp0_err   : rsp1_err;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int            lat, acc, k, both_rdy;
        int            seq [4];
        logic [AS+1:0] d1, d2;
        logic [AS-1:0] rd;
        logic          er, ov;
        int            pick;

        for (int i = 0; i < 256; i++) begin ram_mem[i] = '0; model_mem[i] = '0; end
        rst = 1; tx_en = 1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 0;

        @(negedge clk);
        check("reset rx_valid", rx, 1'b0);
        check("reset din", din, 10'h000);
        check("reset rsp0_rdata", rsp0_rdata, 8'h00);
        @(posedge clk); #1;

        run_txn(0, 1, 8'h12, 8'hA5, lat, d1, d2, rd, er, ov);
        check("write din addr word", d1, 10'h012);
        check("write din data word", d2, 10'h1A5);
        check("write latency", lat, 3);
        check("write err", er, 1'b0);

        run_txn(1, 0, 8'h12, 8'h5A, lat, d1, d2, rd, er, ov);
        check("read din addr word", d1, 10'h212);
        check("read din data word", d2, 10'h300);
        check("read latency", lat, 4);
        check("read rdata", rd, 8'hA5);
        check("read err", er, 1'b0);
        check("read other rsp", ov, 1'b0);

        run_txn(0, 1, 8'hFF, 8'hFF, lat, d1, d2, rd, er, ov);
        check("edge write data word", d2, 10'h1FF);
        run_txn(1, 0, 8'hFF, 8'h00, lat, d1, d2, rd, er, ov);
        check("edge read rdata", rd, 8'hFF);

        tx_en = 0;
        run_txn(0, 0, 8'h12, 8'h00, lat, d1, d2, rd, er, ov);
        check("timeout latency", lat, TO + 4);
        check("timeout err", er, 1'b1);
        check("timeout rdata", rd, 8'h00);
        tx_en = 1;
        run_txn(0, 0, 8'h12, 8'h00, lat, d1, d2, rd, er, ov);
        check("post-timeout latency", lat, 4);
        check("post-timeout rdata", rd, 8'hA5);

        // Both requesters valid continuously from reset.
        rst = 1; @(posedge clk); #1; rst = 0;
        k = 0; both_rdy = 0;
        for (int i = 0; i < 80 && k < 4; i++) begin
            drive(0, 1, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
            drive(1, 1, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
            @(negedge clk);
            if (ready0 && ready1) both_rdy++;
            if (ready0) begin seq[k] = 0; k++; end
            else if (ready1) begin seq[k] = 1; k++; end
            @(posedge clk); #1;
        end
        check("grants seen", k, 4);
        check("grant order", {seq[0][0], seq[1][0], seq[2][0], seq[3][0]}, 4'b0101);
        check("ready both high", both_rdy, 0);
        drive(0, 0, 0, '0, '0); drive(1, 0, 0, '0, '0);
        repeat (25) @(posedge clk); #1;

        // Reset during the DATA cycle of a write.
        drive(0, 1, 1, 8'h33, 8'h44);
        wait_accept(0, acc);
        drive(0, 0, 0, '0, '0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        drive(0, 1, 0, 8'h33, '0); drive(1, 1, 0, 8'h12, '0);
        @(negedge clk);
        check("post-reset rx_valid", rx, 1'b0);
        check("post-reset rsp0_valid", rsp0_valid, 1'b0);
        check("post-reset grant0", ready0, 1'b1);
        check("post-reset grant1", ready1, 1'b0);
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0); drive(1, 0, 0, '0, '0);
        repeat (25) @(posedge clk); #1;

        // Randomized traffic, occasional resets, one phase with the RAM never answering reads.
        for (int p = 0; p < 6; p++) begin
            tx_en = (p != 3);
            for (int c = 0; c < 500; c++) begin
                for (int n = 0; n < 2; n++) begin
                    pick = $urandom_range(0, 9);
                    drive(n, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                          (pick < 8) ? 8'(pick) : ((pick == 8) ? 8'hFF : 8'($urandom)), 8'($urandom));
                end
                rst = ($urandom_range(0, 299) == 0);
                @(posedge clk); #1;
            end
            drive(0, 0, 0, '0, '0); drive(1, 0, 0, '0, '0); rst = 0;
            repeat (25) @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
